bcp_sequencer: RTL and testbench

//  Drives Boolean constraint propagation over binary clauses for the SAT core.

---
 rtl/bcp_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_bcp_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcp_sequencer.sv
// bcp_sequencer: Boolean constraint propagation engine over binary clauses.
// Takes one decision (var, value), owns the assignment/value tables, and walks
// the occurrence list of every newly falsified literal through an external
// occurrence memory, one entry per step. Implied variables go through a small
// FIFO. Propagation ends on fixpoint, conflict or FIFO overflow.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, dec_var, dec_value  decision strobe and payload
//   tbl_clr                    clear both tables (idle only)
//   busy, done                 run status, done is a 1-cycle pulse
//   conflict, conflict_var     contradiction flag and offending variable
//   overflow                   implication FIFO was full on a push
//   occ_req, occ_lit, occ_idx  occurrence read request {var,pol} / entry index
//   occ_ack, occ_valid,
//   occ_var, occ_pol           occurrence response (valid on occ_ack only)
//   assign_table, value_table  bit v = var v assigned / its value
module bcp_sequencer #(
  parameter int unsigned VAR_W   = 12,
  parameter int unsigned VAR_NUM = 4095,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned QDEPTH  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [VAR_W-1:0]   dec_var,
  input  logic               dec_value,
  input  logic               tbl_clr,
  output logic               busy,
  output logic               done,
  output logic               conflict,
  output logic [VAR_W-1:0]   conflict_var,
  output logic               overflow,
  output logic               occ_req,
  output logic [VAR_W:0]     occ_lit,
  output logic [IDX_W-1:0]   occ_idx,
  input  logic               occ_ack,
  input  logic               occ_valid,
  input  logic [VAR_W-1:0]   occ_var,
  input  logic               occ_pol,
  output logic [VAR_NUM:1]   assign_table,
  output logic [VAR_NUM:1]   value_table
);

  localparam int unsigned QPTR_W = $clog2(QDEPTH);
  localparam int unsigned PTR_W  = QPTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_POP,
    S_REQ,
    S_EVAL,
    S_FINISH
  } state_t;

  state_t             state;
  logic [VAR_W-1:0]   dec_var_q;
  logic               dec_value_q;
  logic               r_valid;
  logic [VAR_W-1:0]   r_var;
  logic               r_pol;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [VAR_W-1:0]   fifo_mem [QDEPTH];

  logic               dec_ok_c;
  logic               dec_asg_c;
  logic               dec_val_c;
  logic               y_asg_c;
  logic               y_val_c;
  logic               fifo_empty_c;
  logic               fifo_full_c;
  logic [VAR_W-1:0]   head_c;
  logic               head_val_c;
  logic               push_c;
  logic [VAR_W-1:0]   push_var_c;

  // Table lookups and FIFO status used by the sequencer
  always_comb begin
    dec_ok_c     = (dec_var != '0) && (32'(dec_var) <= VAR_NUM);
    dec_asg_c    = assign_table[dec_var_q];
    dec_val_c    = value_table[dec_var_q];
    y_asg_c      = assign_table[r_var];
    y_val_c      = value_table[r_var];
    fifo_empty_c = (wr_ptr == rd_ptr);
    fifo_full_c  = (wr_ptr[QPTR_W] != rd_ptr[QPTR_W]) &&
                   (wr_ptr[QPTR_W-1:0] == rd_ptr[QPTR_W-1:0]);
    head_c       = fifo_mem[rd_ptr[QPTR_W-1:0]];
    head_val_c   = value_table[head_c];
  end

  // A var is queued only when it is first assigned, so it enters the FIFO at most once per run
  always_comb begin
    push_c     = 1'b0;
    push_var_c = r_var;
    if (state == S_DECIDE && !dec_asg_c) begin
      push_c     = 1'b1;
      push_var_c = dec_var_q;
    end else if (state == S_EVAL && r_valid && !y_asg_c && !fifo_full_c) begin
      push_c = 1'b1;
    end
  end

  // Implication FIFO storage; contents are don't-care outside the pointer window
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr[QPTR_W-1:0]] <= push_var_c;
  end

  // Sequencer: state, tables, FIFO pointers and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      dec_var_q    <= '0;
      dec_value_q  <= 1'b0;
      r_valid      <= 1'b0;
      r_var        <= '0;
      r_pol        <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      conflict     <= 1'b0;
      conflict_var <= '0;
      overflow     <= 1'b0;
      occ_req      <= 1'b0;
      occ_lit      <= '0;
      occ_idx      <= '0;
      assign_table <= '0;
      value_table  <= '0;
    end else begin
      done <= 1'b0;
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      case (state)
        S_IDLE: begin
          // Clear has priority over a coincident start
          if (tbl_clr) begin
            assign_table <= '0;
            value_table  <= '0;
            conflict     <= 1'b0;
            overflow     <= 1'b0;
          end else if (start && dec_ok_c) begin
            dec_var_q    <= dec_var;
            dec_value_q  <= dec_value;
            conflict     <= 1'b0;
            conflict_var <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b1;
            state        <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          if (!dec_asg_c) begin
            assign_table[dec_var_q] <= 1'b1;
            value_table[dec_var_q]  <= dec_value_q;
            state                   <= S_POP;
          end else begin
            if (dec_val_c != dec_value_q) begin
              conflict     <= 1'b1;
              conflict_var <= dec_var_q;
            end
            state <= S_FINISH;
          end
        end
        S_POP: begin
          if (fifo_empty_c) begin
            state <= S_FINISH;
          end else begin
            // Scan the literal of the popped var that its assignment made false
            rd_ptr  <= rd_ptr + PTR_W'(1);
            occ_lit <= {head_c, ~head_val_c};
            occ_idx <= '0;
            occ_req <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (occ_ack) begin
            occ_req <= 1'b0;
            r_valid <= occ_valid;
            r_var   <= occ_var;
            r_pol   <= occ_pol;
            state   <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (!r_valid) begin
            state <= S_POP;
          end else if (y_asg_c && (y_val_c != r_pol)) begin
            conflict     <= 1'b1;
            conflict_var <= r_var;
            state        <= S_FINISH;
          end else begin
            if (!y_asg_c) begin
              assign_table[r_var] <= 1'b1;
              value_table[r_var]  <= r_pol;
            end
            if (!y_asg_c && fifo_full_c) begin
              overflow <= 1'b1;
              state    <= S_FINISH;
            end else if (&occ_idx) begin
              // Last addressable entry: list ends here even if it reported valid
              state <= S_POP;
            end else begin
              occ_idx <= occ_idx + IDX_W'(1);
              occ_req <= 1'b1;
              state   <= S_REQ;
            end
          end
        end
        S_FINISH: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          wr_ptr <= '0;
          rd_ptr <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcp_sequencer.sv
// Directed bench for bcp_sequencer with a small occurrence-memory responder.
module tb_bcp_sequencer;

  localparam int unsigned VW = 4;
  localparam int unsigned VN = 12;
  localparam int unsigned IW = 3;
  localparam int unsigned QD = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [VW-1:0] dec_var;
  logic          dec_value;
  logic          tbl_clr;
  logic          busy;
  logic          done;
  logic          conflict;
  logic [VW-1:0] conflict_var;
  logic          overflow;
  logic          occ_req;
  logic [VW:0]   occ_lit;
  logic [IW-1:0] occ_idx;
  logic          occ_ack;
  logic          occ_valid;
  logic [VW-1:0] occ_var;
  logic          occ_pol;
  logic [VN:1]   assign_table;
  logic [VN:1]   value_table;

  bcp_sequencer #(.VAR_W(VW), .VAR_NUM(VN), .IDX_W(IW), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dec_var(dec_var),
    .dec_value(dec_value), .tbl_clr(tbl_clr), .busy(busy), .done(done),
    .conflict(conflict), .conflict_var(conflict_var), .overflow(overflow),
    .occ_req(occ_req), .occ_lit(occ_lit), .occ_idx(occ_idx),
    .occ_ack(occ_ack), .occ_valid(occ_valid), .occ_var(occ_var),
    .occ_pol(occ_pol), .assign_table(assign_table), .value_table(value_table)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit rand_ack = 0;

  // Occurrence lists indexed by literal {var,pol}
  int       occ_cnt [32];
  logic [VW-1:0] occ_y [32][8];
  logic     occ_p [32][8];
  logic [7:0] req_log [$];

  logic [VN:1] exp_a;
  logic [VN:1] exp_v;

  initial begin
    for (int l = 0; l < 32; l++) occ_cnt[l] = 0;
    // (-5 v 7): falsified lit {5,0} -> other (7,1)
    occ_cnt[10] = 1; occ_y[10][0] = 4'd7; occ_p[10][0] = 1'b1;
    // (-7 v -9): falsified lit {7,0} -> other (9,0)
    occ_cnt[14] = 1; occ_y[14][0] = 4'd9; occ_p[14][0] = 1'b0;
    // (-1 v k) for k = 2..7
    occ_cnt[2] = 6;
    for (int k = 0; k < 6; k++) begin occ_y[2][k] = 4'(k + 2); occ_p[2][k] = 1'b1; end
    // (-10 v 11) repeated across every index slot
    occ_cnt[20] = 8;
    for (int k = 0; k < 8; k++) begin occ_y[20][k] = 4'd11; occ_p[20][k] = 1'b1; end
  end

  // Responder: acks after a chosen delay, logs requests, checks request stability
  initial begin
    int wait_cnt;
    int ack_delay;
    bit prev_req;
    int lit;
    int ix;
    logic [VW:0]   held_lit;
    logic [IW-1:0] held_idx;
    occ_ack = 0; occ_valid = 0; occ_var = '0; occ_pol = 0;
    wait_cnt = 0; ack_delay = 0; prev_req = 0; held_lit = '0; held_idx = '0;
    forever begin
      @(negedge clk);
      occ_ack = 1'b0;
      if (!rst_n) begin
        wait_cnt = 0; prev_req = 0;
      end else if (occ_req === 1'b1) begin
        if (prev_req) begin
          checks++;
          if (occ_lit !== held_lit || occ_idx !== held_idx) begin
            errors++;
            $display("FAIL req_stable got lit %h idx %h exp lit %h idx %h", occ_lit, occ_idx, held_lit, held_idx);
          end
        end else begin
          held_lit = occ_lit; held_idx = occ_idx;
          req_log.push_back({occ_lit, occ_idx});
        end
        prev_req = 1'b1;
        if (wait_cnt >= ack_delay) begin
          lit = int'(occ_lit); ix = int'(occ_idx);
          occ_ack = 1'b1;
          occ_valid = (ix < occ_cnt[lit]);
          occ_var = occ_valid ? occ_y[lit][ix] : '0;
          occ_pol = occ_valid ? occ_p[lit][ix] : 1'b0;
          wait_cnt = 0; prev_req = 1'b0;
          if (rand_ack) begin
            case ($urandom_range(0, 2))
              0: ack_delay = 0;
              1: ack_delay = 1;
              default: ack_delay = 5;
            endcase
          end else ack_delay = 0;
        end else wait_cnt++;
      end else prev_req = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
  end

  task automatic do_start(input logic [VW-1:0] v, input logic val);
    @(negedge clk);
    dec_var = v; dec_value = val; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [VW-1:0] v, input logic val, input string nm);
    int n;
    do_start(v, val);
    n = 0;
    while (done !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s_done timeout got %b exp 1", nm, done); end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic clear_tables();
    @(negedge clk); tbl_clr = 1'b1;
    @(negedge clk); tbl_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, conflict, overflow, occ_req} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {busy, done, conflict, overflow, occ_req});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (assign_table !== '0 || value_table !== '0) begin
      errors++; $display("FAIL reset_tables got %h/%h exp 0/0", assign_table, value_table);
    end
  endtask

  task automatic test_bad_start();
    bit seen;
    int d0;
    d0 = done_cnt;
    for (int t = 0; t < 2; t++) begin
      seen = 0;
      do_start(t == 0 ? 4'd0 : 4'd13, 1'b1);
      repeat (4) begin if (busy !== 1'b0) seen = 1; @(negedge clk); end
      checks++;
      if (seen) begin errors++; $display("FAIL bad_start_busy var %0d got busy exp no busy", t == 0 ? 0 : 13); end
    end
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL bad_start_done got %0d exp 0", done_cnt - d0); end
  endtask

  task automatic test_single();
    int n;
    do_start(4'd8, 1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done got done %b busy %b exp 1 0", done, busy);
    end
    @(negedge clk);
    exp_a = '0; exp_a[8] = 1'b1; exp_v = exp_a;
    checks++;
    if (assign_table !== exp_a || value_table !== exp_v || conflict !== 1'b0) begin
      errors++; $display("FAIL single_tables got %h/%h c%b exp %h/%h c0", assign_table, value_table, conflict, exp_a, exp_v);
    end
  endtask

  task automatic test_chain();
    logic [7:0] exp_log [5];
    exp_log = '{{5'd10, 3'd0}, {5'd10, 3'd1}, {5'd14, 3'd0}, {5'd14, 3'd1}, {5'd19, 3'd0}};
    clear_tables();
    checks++;
    if (assign_table !== '0) begin errors++; $display("FAIL clr_tables got %h exp 0", assign_table); end
    req_log.delete();
    run(4'd5, 1'b1, "chain");
    exp_a = '0; exp_a[5] = 1; exp_a[7] = 1; exp_a[9] = 1;
    exp_v = '0; exp_v[5] = 1; exp_v[7] = 1;
    checks++;
    if (assign_table !== exp_a || value_table !== exp_v || conflict !== 1'b0) begin
      errors++; $display("FAIL chain_tables got %h/%h c%b exp %h/%h c0", assign_table, value_table, conflict, exp_a, exp_v);
    end
    checks++;
    if (req_log.size() != 5) begin errors++; $display("FAIL chain_nreq got %0d exp 5", req_log.size()); end
    for (int i = 0; i < 5 && i < req_log.size(); i++) begin
      checks++;
      if (req_log[i] !== exp_log[i]) begin errors++; $display("FAIL chain_req%0d got %h exp %h", i, req_log[i], exp_log[i]); end
    end
  endtask

  task automatic test_conflict();
    clear_tables();
    run(4'd9, 1'b1, "preset");
    run(4'd5, 1'b1, "imp_conflict");
    exp_a = '0; exp_a[5] = 1; exp_a[7] = 1; exp_a[9] = 1;
    exp_v = exp_a;
    checks++;
    if (conflict !== 1'b1 || conflict_var !== 4'd9) begin
      errors++; $display("FAIL imp_conflict got %b var %0d exp 1 var 9", conflict, conflict_var);
    end
    checks++;
    if (assign_table !== exp_a || value_table !== exp_v) begin
      errors++; $display("FAIL conflict_tables got %h/%h exp %h/%h", assign_table, value_table, exp_a, exp_v);
    end
    run(4'd5, 1'b0, "dec_conflict");
    checks++;
    if (conflict !== 1'b1 || conflict_var !== 4'd5) begin
      errors++; $display("FAIL dec_conflict got %b var %0d exp 1 var 5", conflict, conflict_var);
    end
    run(4'd5, 1'b1, "dec_same");
    checks++;
    if (conflict !== 1'b0) begin errors++; $display("FAIL dec_same got %b exp 0", conflict); end
  endtask

  task automatic test_overflow();
    int n;
    clear_tables();
    run(4'd1, 1'b1, "overflow");
    exp_a = '0;
    for (int k = 1; k <= 6; k++) exp_a[k] = 1'b1;
    exp_v = exp_a;
    checks++;
    if (overflow !== 1'b1 || conflict !== 1'b0) begin
      errors++; $display("FAIL overflow_flag got ov %b c %b exp 1 0", overflow, conflict);
    end
    checks++;
    if (assign_table !== exp_a || value_table !== exp_v) begin
      errors++; $display("FAIL overflow_tables got %h/%h exp %h/%h", assign_table, value_table, exp_a, exp_v);
    end
    do_start(4'd8, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b exp 0", overflow); end
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL overflow_rerun timeout got %b exp 1", done); end
    @(negedge clk);
  endtask

  task automatic test_idx_wrap();
    logic [7:0] e;
    clear_tables();
    req_log.delete();
    run(4'd10, 1'b1, "wrap");
    exp_a = '0; exp_a[10] = 1; exp_a[11] = 1; exp_v = exp_a;
    checks++;
    if (assign_table !== exp_a || value_table !== exp_v) begin
      errors++; $display("FAIL wrap_tables got %h/%h exp %h/%h", assign_table, value_table, exp_a, exp_v);
    end
    checks++;
    if (req_log.size() != 9) begin errors++; $display("FAIL wrap_nreq got %0d exp 9", req_log.size()); end
    for (int i = 0; i < 9 && i < req_log.size(); i++) begin
      e = (i < 8) ? {5'd20, 3'(i)} : {5'd22, 3'd0};
      checks++;
      if (req_log[i] !== e) begin errors++; $display("FAIL wrap_req%0d got %h exp %h", i, req_log[i], e); end
    end
  endtask

  task automatic test_random_ack();
    int d0;
    rand_ack = 1;
    exp_a = '0; exp_a[5] = 1; exp_a[7] = 1; exp_a[9] = 1;
    exp_v = '0; exp_v[5] = 1; exp_v[7] = 1;
    for (int r = 0; r < 4; r++) begin
      clear_tables();
      d0 = done_cnt;
      run(4'd5, 1'b1, "rand");
      repeat (3) @(negedge clk);
      checks++;
      if (assign_table !== exp_a || value_table !== exp_v || done_cnt - d0 != 1) begin
        errors++; $display("FAIL rand_run%0d got %h/%h dones %0d exp %h/%h dones 1", r, assign_table, value_table, done_cnt - d0, exp_a, exp_v);
      end
    end
    rand_ack = 0;
  endtask

  task automatic test_back_to_back();
    int d0;
    int n;
    clear_tables();
    d0 = done_cnt;
    do_start(4'd5, 1'b1);
    dec_var = 4'd8; start = 1'b1;
    @(negedge clk); start = 1'b0; tbl_clr = 1'b1;
    @(negedge clk); tbl_clr = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    exp_a = '0; exp_a[5] = 1; exp_a[7] = 1; exp_a[9] = 1;
    exp_v = '0; exp_v[5] = 1; exp_v[7] = 1;
    checks++;
    if (assign_table !== exp_a || value_table !== exp_v || done_cnt - d0 != 1) begin
      errors++; $display("FAIL busy_ignore got %h/%h dones %0d exp %h/%h dones 1", assign_table, value_table, done_cnt - d0, exp_a, exp_v);
    end
    // Coincident clear and start: clear wins, no run
    d0 = done_cnt;
    @(negedge clk); dec_var = 4'd8; start = 1'b1; tbl_clr = 1'b1;
    @(negedge clk); start = 1'b0; tbl_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || assign_table !== '0 || done_cnt != d0) begin
      errors++; $display("FAIL clr_vs_start got busy %b tbl %h dones %0d exp 0 0 0", busy, assign_table, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int falls;
    int n;
    bit prev;
    falls = 0; n = 0; prev = 0;
    do_start(4'd5, 1'b1);
    while (falls < 2 && n < 200) begin
      @(negedge clk); n++;
      if (prev && occ_req === 1'b0) falls++;
      prev = (occ_req === 1'b1);
    end
    checks++;
    if (falls != 2 || assign_table[7] !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_reach got falls %0d a7 %b busy %b exp 2 1 1", falls, assign_table[7], busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (assign_table !== '0 || value_table !== '0) begin
      errors++; $display("FAIL mid_rst_tables got %h/%h exp 0/0", assign_table, value_table);
    end
    checks++;
    if ({busy, done, conflict, overflow, occ_req} !== 5'b0 || occ_lit !== '0 || occ_idx !== '0 || conflict_var !== '0) begin
      errors++; $display("FAIL mid_rst_outs got %b lit %h idx %h cv %h exp 0", {busy, done, conflict, overflow, occ_req}, occ_lit, occ_idx, conflict_var);
    end
    @(negedge clk); rst_n = 1'b1;
    run(4'd8, 1'b1, "post_rst");
    exp_a = '0; exp_a[8] = 1;
    checks++;
    if (assign_table !== exp_a) begin errors++; $display("FAIL post_rst_tables got %h exp %h", assign_table, exp_a); end
  endtask

  initial begin
    start = 1'b0; dec_var = '0; dec_value = 1'b0; tbl_clr = 1'b0; rst_n = 1'b0;
    test_reset();
    test_bad_start();
    test_single();
    test_chain();
    test_conflict();
    test_overflow();
    test_idx_wrap();
    test_random_ack();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
